// File: rtl/morra_arbitro.sv
// Match sequencer for the morra cinese core: loads the match length, collects one move per
// player per manche, strobes each pair into the core and counts valid manches. Optional macro: MORRA_TIMEOUT_EN.
module morra_arbitro #(
    parameter int TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       AVVIO,
    input  logic [3:0] CFG_MANCHE,
    input  logic       P1_VALID,
    input  logic [1:0] P1_MOSSA,
    output logic       P1_READY,
    input  logic       P2_VALID,
    input  logic [1:0] P2_MOSSA,
    output logic       P2_READY,
    output logic       CORE_INIZIA,
    output logic [1:0] CORE_PRIMO,
    output logic [1:0] CORE_SECONDO,
    output logic       CORE_VALID,
    input  logic [1:0] CORE_MANCHE,
    output logic [4:0] MANCHE_NUM,
    output logic       BUSY,
    output logic       FINE,
    output logic       TIMEOUT_ERR
);

    typedef enum logic [2:0] {
        S_IDLE, S_CONFIG, S_RACCOLTA, S_INVIO, S_ATTESA, S_FINE
    } state_t;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("morra_arbitro: TIMEOUT must be in 2..255");
    end

    state_t     r_state, w_state_n;
    logic [4:0] r_target, w_target_n;
    logic [4:0] r_num, w_num_n;
    logic       r_cap1, w_cap1_n, r_cap2, w_cap2_n;
    logic [1:0] r_mossa1, w_mossa1_n, r_mossa2, w_mossa2_n;
    logic       r_p1_ready, r_p2_ready, r_inizia, r_core_valid, r_busy, r_fine;
    logic [1:0] r_primo, r_secondo;
    logic       w_take1, w_take2;

    // A handshake only captures a real move; 00 is dropped and the player stays ready.
    assign w_take1 = P1_VALID & r_p1_ready & (P1_MOSSA != 2'b00);
    assign w_take2 = P2_VALID & r_p2_ready & (P2_MOSSA != 2'b00);

`ifdef MORRA_TIMEOUT_EN
    logic [7:0] r_cnt, w_cnt_n;
    logic       r_tout, w_tout_n;
`endif

    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    always_comb begin
        w_state_n  = r_state;
        w_target_n = r_target;
        w_num_n    = r_num;
        w_cap1_n   = r_cap1;
        w_cap2_n   = r_cap2;
        w_mossa1_n = r_mossa1;
        w_mossa2_n = r_mossa2;
`ifdef MORRA_TIMEOUT_EN
        w_cnt_n    = r_cnt;
        w_tout_n   = 1'b0;
`endif
        unique case (r_state)
            S_IDLE, S_FINE: begin
                if (AVVIO) begin
                    w_state_n  = S_CONFIG;
                    w_target_n = 5'd4 + {1'b0, CFG_MANCHE};
                    w_num_n    = '0;
                end
            end
            S_CONFIG: begin
                w_state_n  = S_RACCOLTA;
                w_cap1_n   = 1'b0;
                w_cap2_n   = 1'b0;
                w_mossa1_n = '0;
                w_mossa2_n = '0;
`ifdef MORRA_TIMEOUT_EN
                w_cnt_n    = '0;
`endif
            end
            S_RACCOLTA: begin
                if (w_take1) begin
                    w_cap1_n   = 1'b1;
                    w_mossa1_n = P1_MOSSA;
                end
                if (w_take2) begin
                    w_cap2_n   = 1'b1;
                    w_mossa2_n = P2_MOSSA;
                end
                if (w_cap1_n && w_cap2_n) begin
                    w_state_n = S_INVIO;
`ifdef MORRA_TIMEOUT_EN
                end else if (r_cnt == 8'(TIMEOUT)) begin
                    // Abort and restart collection of the same manche.
                    w_tout_n   = 1'b1;
                    w_cap1_n   = 1'b0;
                    w_cap2_n   = 1'b0;
                    w_mossa1_n = '0;
                    w_mossa2_n = '0;
                    w_cnt_n    = '0;
                end else begin
                    w_cnt_n = r_cnt + 8'd1;
`endif
                end
            end
            S_INVIO: w_state_n = S_ATTESA;
            S_ATTESA: begin
                if (CORE_MANCHE != 2'b00) begin
                    w_num_n = r_num + 5'd1;
                end
                if (w_num_n == r_target) begin
                    w_state_n = S_FINE;
                end else begin
                    w_state_n  = S_RACCOLTA;
                    w_cap1_n   = 1'b0;
                    w_cap2_n   = 1'b0;
                    w_mossa1_n = '0;
                    w_mossa2_n = '0;
`ifdef MORRA_TIMEOUT_EN
                    w_cnt_n    = '0;
`endif
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_target     <= '0;
            r_num        <= '0;
            r_cap1       <= 1'b0;
            r_cap2       <= 1'b0;
            r_mossa1     <= '0;
            r_mossa2     <= '0;
            r_p1_ready   <= 1'b0;
            r_p2_ready   <= 1'b0;
            r_inizia     <= 1'b0;
            r_core_valid <= 1'b0;
            r_primo      <= '0;
            r_secondo    <= '0;
            r_busy       <= 1'b0;
            r_fine       <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_target     <= w_target_n;
            r_num        <= w_num_n;
            r_cap1       <= w_cap1_n;
            r_cap2       <= w_cap2_n;
            r_mossa1     <= w_mossa1_n;
            r_mossa2     <= w_mossa2_n;
            // Outputs are decoded from the next state so they are registered, not combinational.
            r_p1_ready   <= (w_state_n == S_RACCOLTA) && !w_cap1_n;
            r_p2_ready   <= (w_state_n == S_RACCOLTA) && !w_cap2_n;
            r_inizia     <= (w_state_n == S_CONFIG);
            r_core_valid <= (w_state_n == S_INVIO);
            r_primo      <= (w_state_n == S_CONFIG) ? CFG_MANCHE[3:2] : w_mossa1_n;
            r_secondo    <= (w_state_n == S_CONFIG) ? CFG_MANCHE[1:0] : w_mossa2_n;
            r_busy       <= (w_state_n != S_IDLE) && (w_state_n != S_FINE);
            r_fine       <= (w_state_n == S_FINE);
        end
    end

`ifdef MORRA_TIMEOUT_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt  <= '0;
            r_tout <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_n;
            r_tout <= w_tout_n;
        end
    end
    assign TIMEOUT_ERR = r_tout;
`else
    assign TIMEOUT_ERR = 1'b0;
`endif

    assign P1_READY     = r_p1_ready;
    assign P2_READY     = r_p2_ready;
    assign CORE_INIZIA  = r_inizia;
    assign CORE_PRIMO   = r_primo;
    assign CORE_SECONDO = r_secondo;
    assign CORE_VALID   = r_core_valid;
    assign MANCHE_NUM   = r_num;
    assign BUSY         = r_busy;
    assign FINE         = r_fine;

endmodule
